// File: rtl/conv_seq_pkg.sv
// Shared types and sizing helpers for the 1x1-conv expand layer sequencer.
package conv_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  function automatic int calc_npix(input int wout);
    return wout * wout;
  endfunction

  function automatic int calc_run_cycles(input int wout, input int chin);
    return calc_npix(wout) * (chin + 1);
  endfunction

  localparam int DEF_WOUT   = 8;
  localparam int DEF_CHIN   = 112;
  localparam int NPIX       = calc_npix(DEF_WOUT);
  localparam int RUN_CYCLES = calc_run_cycles(DEF_WOUT, DEF_CHIN);

endpackage

// File: rtl/seq_addr_gen.sv
// Pixel/channel counters with a running ifm read address (no multiplier).
// Each pixel spends CHIN read slots plus one gap slot that lines up with the datapath clr.
module seq_addr_gen #(
  parameter int CHIN   = 112,
  parameter int NPIX   = 64,
  parameter int IFM_AW = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              step,
  output logic [IFM_AW-1:0] addr,
  output logic              gap,
  output logic              last
);

  localparam int CH_W  = $clog2(CHIN + 1);
  localparam int PIX_W = $clog2(NPIX + 1);

  localparam logic [CH_W-1:0]  CH_GAP     = CH_W'(CHIN);
  localparam logic [CH_W-1:0]  CH_LAST_RD = CH_W'(CHIN - 1);
  localparam logic [PIX_W-1:0] PIX_LAST   = PIX_W'(NPIX - 1);

  logic [CH_W-1:0]  ch_q;
  logic [PIX_W-1:0] pix_q;
  logic [IFM_AW-1:0] addr_q;

  assign gap  = (ch_q == CH_GAP);
  assign last = gap && (pix_q == PIX_LAST);
  assign addr = addr_q;

  // The address holds through the last read and the gap, then steps onto the next pixel base.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ch_q   <= '0;
      pix_q  <= '0;
      addr_q <= '0;
    end else if (step) begin
      if (gap) begin
        ch_q <= '0;
        if (last) begin
          pix_q  <= '0;
          addr_q <= '0;
        end else begin
          pix_q  <= pix_q + PIX_W'(1);
          addr_q <= addr_q + IFM_AW'(1);
        end
      end else begin
        ch_q <= ch_q + CH_W'(1);
        if (ch_q != CH_LAST_RD) begin
          addr_q <= addr_q + IFM_AW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/conv1x1_layer_seq.sv
// Layer sequencer: runs the MAC array for one 1x1 expand layer, turns sample pulses
// into ofm writes, and reports done/err to the network scheduler.
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | layer_en high, ifm reads issued, pixels stepped
//   DRAIN | waiting for outstanding samples, watchdog running
//   DONE  | one-cycle done / ram_feedback pulse
module conv1x1_layer_seq
  import conv_seq_pkg::*;
#(
  parameter int WOUT          = 8,
  parameter int CHIN          = 112,
  parameter int IFM_AW        = 13,
  parameter int OFM_AW        = 7,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              layer_en,
  output logic              ifm_rd_en,
  output logic [IFM_AW-1:0] ifm_rd_addr,
  input  logic              layer_sample,
  output logic              ofm_wr_en,
  output logic [OFM_AW-1:0] ofm_wr_addr,
  output logic              busy,
  output logic              done,
  output logic              ram_feedback,
  output logic              err
);

  localparam int LNPIX  = calc_npix(WOUT);
  localparam int SAMP_W = $clog2(LNPIX + 1);
  localparam int TMR_W  = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [SAMP_W-1:0] SAMP_FULL = SAMP_W'(LNPIX);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(DRAIN_TIMEOUT - 1);

  if ((64'(1) << IFM_AW) < 64'(LNPIX * CHIN)) begin : g_ifm_aw_chk
    $error("IFM_AW cannot hold WOUT^2*CHIN-1");
  end
  if ((64'(1) << OFM_AW) < 64'(LNPIX)) begin : g_ofm_aw_chk
    $error("OFM_AW cannot hold WOUT^2-1");
  end
  if (DRAIN_TIMEOUT < 1 || CHIN < 1 || WOUT < 1) begin : g_param_chk
    $error("WOUT, CHIN and DRAIN_TIMEOUT must be at least 1");
  end

  seq_state_e        state_q, state_d;
  logic [SAMP_W-1:0] samp_q;
  logic [TMR_W-1:0]  timer_q;
  logic              wr_en_q;
  logic [OFM_AW-1:0] wr_addr_q;
  logic              err_q;
  logic              gen_gap, gen_last;
  logic              accept, sample_live, drain_complete, drain_expire;

  assign accept         = (state_q == IDLE) && start;
  assign sample_live    = (state_q != IDLE) && layer_sample;
  assign drain_complete = (samp_q == SAMP_FULL) && !wr_en_q;
  assign drain_expire   = (timer_q == TMR_LAST);

  seq_addr_gen #(
    .CHIN   (CHIN),
    .NPIX   (LNPIX),
    .IFM_AW (IFM_AW)
  ) u_addr_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .step  (state_q == RUN),
    .addr  (ifm_rd_addr),
    .gap   (gen_gap),
    .last  (gen_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    layer_en     = 1'b0;
    ifm_rd_en    = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    ram_feedback = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = RUN;
      end
      RUN: begin
        layer_en  = 1'b1;
        ifm_rd_en = !gen_gap;
        if (gen_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (drain_complete)    state_d = DONE;
        else if (drain_expire) state_d = IDLE;
      end
      DONE: begin
        done         = 1'b1;
        ram_feedback = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A sample registers a write for the following cycle, when the ofm bus is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      wr_en_q <= 1'b0;
      if (accept) begin
        samp_q <= '0;
      end else if (sample_live && (samp_q != SAMP_FULL)) begin
        wr_en_q   <= 1'b1;
        wr_addr_q <= OFM_AW'(samp_q);
        samp_q    <= samp_q + SAMP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                     timer_q <= '0;
    else if (state_q == DRAIN)   timer_q <= timer_q + TMR_W'(1);
    else                         timer_q <= '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if ((sample_live && (samp_q == SAMP_FULL)) ||
                 ((state_q == DRAIN) && !drain_complete && drain_expire)) begin
      err_q <= 1'b1;
    end
  end

  assign ofm_wr_en   = wr_en_q;
  assign ofm_wr_addr = wr_addr_q;
  assign err         = err_q;

endmodule

// File: tb/tb_conv1x1_layer_seq.sv
// Bench for conv1x1_layer_seq with a small layer (WOUT=2, CHIN=3, DRAIN_TIMEOUT=8).
// Expected outputs come from a run timeline derived with plain arithmetic per layer run.
module tb_conv1x1_layer_seq;

  localparam int WOUT = 2;
  localparam int CHIN = 3;
  localparam int IFM_AW = 4;
  localparam int OFM_AW = 2;
  localparam int DRAIN_TIMEOUT = 8;
  localparam int NPIX = WOUT * WOUT;
  localparam int R = NPIX * (CHIN + 1);
  localparam int MAXC = 64;

  logic clk = 1'b0;
  logic rst, start, layer_sample;
  logic layer_en, ifm_rd_en, ofm_wr_en, busy, done, ram_feedback, err;
  logic [IFM_AW-1:0] ifm_rd_addr;
  logic [OFM_AW-1:0] ofm_wr_addr;

  int errors = 0;
  int checks = 0;
  bit samp_at [MAXC];
  bit xstart_at [MAXC];

  always #5 clk = ~clk;

  conv1x1_layer_seq #(
    .WOUT(WOUT), .CHIN(CHIN), .IFM_AW(IFM_AW), .OFM_AW(OFM_AW), .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .layer_en(layer_en), .ifm_rd_en(ifm_rd_en),
    .ifm_rd_addr(ifm_rd_addr), .layer_sample(layer_sample), .ofm_wr_en(ofm_wr_en),
    .ofm_wr_addr(ofm_wr_addr), .busy(busy), .done(done), .ram_feedback(ram_feedback), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
      $error("check %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " layer_en"}, 32'(layer_en), 0);
    check({tag, " ifm_rd_en"}, 32'(ifm_rd_en), 0);
    check({tag, " ifm_rd_addr"}, 32'(ifm_rd_addr), 0);
    check({tag, " ofm_wr_en"}, 32'(ofm_wr_en), 0);
    check({tag, " ofm_wr_addr"}, 32'(ofm_wr_addr), 0);
    check({tag, " busy"}, 32'(busy), 0);
    check({tag, " done"}, 32'(done), 0);
    check({tag, " ram_feedback"}, 32'(ram_feedback), 0);
    check({tag, " err"}, 32'(err), 0);
  endtask

  // Start is driven in cycle 0 of the run; samp_at/xstart_at give per-cycle stimulus.
  // rst_cyc > 0 asserts reset during that cycle and ends the run one cycle later.
  task automatic run_layer(input string name, input int rst_cyc);
    bit exp_wr [MAXC];
    int exp_wa [MAXC];
    int n, w_last, d, done_cyc, end_cyc, err_cyc, p, chn;
    logic [31:0] ea;
    string tg;
    for (int i = 0; i < MAXC; i++) begin
      exp_wr[i] = 1'b0;
      exp_wa[i] = 0;
    end
    n = 0;
    w_last = -1;
    err_cyc = 1000;
    for (int c = 1; c < MAXC - 1; c++) begin
      if (samp_at[c]) begin
        if (n < NPIX) begin
          exp_wr[c+1] = 1'b1;
          exp_wa[c+1] = n;
          n++;
          if (n == NPIX) w_last = c + 1;
        end else if (c + 1 < err_cyc) begin
          err_cyc = c + 1;
        end
      end
    end
    d = (w_last + 1 > R + 1) ? w_last + 1 : R + 1;
    done_cyc = -1;
    if (n == NPIX && d <= R + DRAIN_TIMEOUT) begin
      done_cyc = d + 1;
      end_cyc = d + 2;
    end else begin
      end_cyc = R + DRAIN_TIMEOUT + 1;
      if (end_cyc < err_cyc) err_cyc = end_cyc;
    end
    if (rst_cyc > 0) end_cyc = rst_cyc + 1;

    for (int c = 0; c <= end_cyc; c++) begin
      tg = $sformatf("%s c%0d", name, c);
      if (rst_cyc > 0 && c == rst_cyc + 1) begin
        check_all_zero({tg, " after_rst"});
      end else begin
        check({tg, " layer_en"}, 32'(layer_en), 32'(c >= 1 && c <= R));
        check({tg, " busy"}, 32'(busy), 32'(c >= 1 && c < end_cyc));
        check({tg, " done"}, 32'(done), 32'(c == done_cyc));
        check({tg, " ram_feedback"}, 32'(ram_feedback), 32'(c == done_cyc));
        check({tg, " ofm_wr_en"}, 32'(ofm_wr_en), 32'(exp_wr[c]));
        if (exp_wr[c]) check({tg, " ofm_wr_addr"}, 32'(ofm_wr_addr), 32'(exp_wa[c]));
        if (c >= 1) check({tg, " err"}, 32'(err), 32'(c >= err_cyc));
        if (c >= 1 && c <= R) begin
          p = (c - 1) / (CHIN + 1);
          chn = (c - 1) % (CHIN + 1);
          ea = (chn < CHIN) ? 32'(p * CHIN + chn) : 32'(p * CHIN + CHIN - 1);
          check({tg, " ifm_rd_en"}, 32'(ifm_rd_en), 32'(chn < CHIN));
          check({tg, " ifm_rd_addr"}, 32'(ifm_rd_addr), ea);
        end else begin
          check({tg, " ifm_rd_en"}, 32'(ifm_rd_en), 0);
        end
      end
      start = (c == 0) || xstart_at[c];
      layer_sample = samp_at[c];
      rst = (rst_cyc > 0 && c == rst_cyc);
      if (c < end_cyc) tick();
    end
    start = 1'b0;
    layer_sample = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < MAXC; i++) begin
      samp_at[i] = 1'b0;
      xstart_at[i] = 1'b0;
    end
    tick();
  endtask

  initial begin
    int k, cyc;
    rst = 1'b1;
    start = 1'b0;
    layer_sample = 1'b0;
    tick();
    start = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    start = 1'b0;
    tick();
    check_all_zero("reset_state");

    samp_at[6] = 1; samp_at[10] = 1; samp_at[14] = 1; samp_at[18] = 1;
    run_layer("basic", 0);

    samp_at[6] = 1; samp_at[10] = 1; samp_at[14] = 1;
    run_layer("timeout", 0);

    samp_at[6] = 1; samp_at[10] = 1; samp_at[14] = 1; samp_at[18] = 1; samp_at[21] = 1;
    run_layer("extra_in_done", 0);

    samp_at[6] = 1; samp_at[10] = 1; samp_at[14] = 1; samp_at[18] = 1; samp_at[20] = 1;
    run_layer("extra_in_drain", 0);

    samp_at[3] = 1; samp_at[5] = 1; samp_at[7] = 1;
    run_layer("reset_mid_run", 7);

    samp_at[2] = 1; samp_at[3] = 1; samp_at[9] = 1; samp_at[16] = 1;
    xstart_at[5] = 1; xstart_at[17] = 1;
    run_layer("restart_ignore_start", 0);

    for (int r = 0; r < 6; r++) begin
      k = $urandom_range(4, 3);
      for (int j = 0; j < k; j++) begin
        do cyc = $urandom_range(R + 5, 1); while (samp_at[cyc]);
        samp_at[cyc] = 1'b1;
      end
      xstart_at[$urandom_range(R, 1)] = 1'b1;
      xstart_at[$urandom_range(R, 1)] = 1'b1;
      run_layer($sformatf("rand%0d", r), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench did not complete");
  end

endmodule
